// File: rtl/imm_field_encoder_pkg.sv
// Shared constants and the field-packing helper for the immediate encoder
// and the branch-offset range checker.
package imm_field_encoder_pkg;

    typedef enum logic [1:0] {
        SEL_IMM8 = 2'd0,
        SEL_HI4  = 2'd1,
        SEL_LO4  = 2'd2,
        SEL_RSVD = 2'd3
    } sel_e;

    localparam int W_IMM8 = 8;
    localparam int W_NIB  = 4;

    localparam logic [7:0] LIM8_MAX = 8'h7F;
    localparam logic [7:0] LIM8_MIN = 8'h80;
    localparam logic [3:0] LIM4_MAX = 4'h7;
    localparam logic [3:0] LIM4_MIN = 4'h8;

    // Builds the immediate byte; the reserved select passes the base byte through.
    function automatic logic [7:0] pack_field(
        input logic [7:0] low,
        input sel_e       sel,
        input logic [7:0] base,
        input logic       sat_en,
        input logic       sat_hi,
        input logic       sat_lo
    );
        logic [7:0] f8;
        logic [3:0] f4;
        logic [7:0] result;
        f8 = low;
        f4 = low[3:0];
        if (sat_en && sat_hi) begin
            f8 = LIM8_MAX;
            f4 = LIM4_MAX;
        end else if (sat_en && sat_lo) begin
            f8 = LIM8_MIN;
            f4 = LIM4_MIN;
        end
        case (sel)
            SEL_IMM8: result = f8;
            SEL_HI4:  result = {f4, base[3:0]};
            SEL_LO4:  result = {base[7:4], f4};
            default:  result = base;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/imm_field_encoder_range_check.sv
// Combinational fit test of a 16-bit signed value against the selected field.
// The reserved select reports a fit so it never raises overflow.
module imm_range_check
    import imm_field_encoder_pkg::*;
(
    input  logic [15:0] value,
    input  sel_e        sel,
    output logic        fits,
    output logic        sat_hi,
    output logic        sat_lo
);

    logic fit8;
    logic fit4;

    // A value fits when every bit from the field's sign bit upward agrees.
    assign fit8 = (&value[15:W_IMM8-1]) | ~(|value[15:W_IMM8-1]);
    assign fit4 = (&value[15:W_NIB-1])  | ~(|value[15:W_NIB-1]);

    always_comb begin
        fits = 1'b1;
        case (sel)
            SEL_IMM8:         fits = fit8;
            SEL_HI4, SEL_LO4: fits = fit4;
            default:          fits = 1'b1;
        endcase
    end

    assign sat_hi = ~fits & ~value[15];
    assign sat_lo = ~fits &  value[15];

endmodule

// File: rtl/imm_field_encoder.sv
// Two-stage valid/ready encoder packing a signed value into the 8-bit
// instruction immediate, with optional saturation and a sticky overflow count.
module imm_field_encoder
    import imm_field_encoder_pkg::*;
#(
    parameter logic        SAT   = 1'b1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_value,
    input  logic [1:0]       in_sel,
    input  logic [7:0]       in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_field,
    output logic             out_ovf,
    output logic             out_bad_sel,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    logic        s1_valid;
    logic [15:0] s1_value;
    sel_e        s1_sel;
    logic [7:0]  s1_base;
    logic        s2_valid;

    logic        s1_adv;
    logic        s2_adv;
    logic        fits;
    logic        sat_hi;
    logic        sat_lo;
    logic [7:0]  field_nxt;
    logic        count_inc;

    // An empty S2 always advances, so bubbles collapse under back-pressure.
    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = s2_valid;

    imm_range_check u_range (
        .value  (s1_value),
        .sel    (s1_sel),
        .fits   (fits),
        .sat_hi (sat_hi),
        .sat_lo (sat_lo)
    );

    assign field_nxt = pack_field(s1_value[7:0], s1_sel, s1_base, SAT, sat_hi, sat_lo);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_value    <= '0;
            s1_sel      <= SEL_IMM8;
            s1_base     <= '0;
            s2_valid    <= 1'b0;
            out_field   <= '0;
            out_ovf     <= 1'b0;
            out_bad_sel <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_value <= in_value;
                    s1_sel   <= sel_e'(in_sel);
                    s1_base  <= in_base;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_field   <= field_nxt;
                    out_ovf     <= ~fits;
                    out_bad_sel <= (s1_sel == SEL_RSVD);
                end
            end
        end
    end

    assign count_inc = s2_valid & out_ready & (out_ovf | out_bad_sel);

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            ovf_count <= '0;
        end else if (count_inc && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Scoreboard bench: a saturating and a wrapping encoder share all inputs;
// each expected entry holds the hand-computed result for both.
module tb_imm_field_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_value;
    logic [1:0]  in_sel;
    logic [7:0]  in_base;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready_s, out_valid_s, out_ovf_s, out_bad_s;
    logic [7:0]  out_field_s, count_s;
    logic        in_ready_w, out_valid_w, out_ovf_w, out_bad_w;
    logic [7:0]  out_field_w, count_w;

    always #5 clk = ~clk;

    imm_field_encoder #(.SAT(1'b1), .CNT_W(8)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_value(in_value), .in_sel(in_sel), .in_base(in_base),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_field(out_field_s),
        .out_ovf(out_ovf_s), .out_bad_sel(out_bad_s), .ovf_count(count_s),
        .clr_count(clr_count)
    );

    imm_field_encoder #(.SAT(1'b0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_value(in_value), .in_sel(in_sel), .in_base(in_base),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_field(out_field_w),
        .out_ovf(out_ovf_w), .out_bad_sel(out_bad_w), .ovf_count(count_w),
        .clr_count(clr_count)
    );

    typedef struct {
        logic [7:0] fs;
        logic [7:0] fw;
        logic       ovf;
        logic       bad;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic       prev_hold = 1'b0;
    logic [7:0] prev_fs;
    logic [7:0] prev_fw;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, out_valid_s}, 32'd1);
                check("hold_field_sat", {24'd0, out_field_s}, {24'd0, prev_fs});
                check("hold_field_wrap", {24'd0, out_field_w}, {24'd0, prev_fw});
            end
            if (out_valid_s && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat field=%0h at %0t", out_field_s, $time);
                end else begin
                    e = q.pop_front();
                    check("field_sat", {24'd0, out_field_s}, {24'd0, e.fs});
                    check("field_wrap", {24'd0, out_field_w}, {24'd0, e.fw});
                    check("valid_wrap", {31'd0, out_valid_w}, 32'd1);
                    check("ovf_sat", {31'd0, out_ovf_s}, {31'd0, e.ovf});
                    check("ovf_wrap", {31'd0, out_ovf_w}, {31'd0, e.ovf});
                    check("bad_sel", {31'd0, out_bad_s}, {31'd0, e.bad});
                end
            end
            prev_hold = out_valid_s && !out_ready;
            prev_fs   = out_field_s;
            prev_fw   = out_field_w;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] v, input logic [1:0] s, input logic [7:0] b,
                        input logic [7:0] fs, input logic [7:0] fw,
                        input logic ovf, input logic bad);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_value = v;
        in_sel   = s;
        in_base  = b;
        @(negedge clk);
        while (!in_ready_s && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready_s) begin
            checks++;
            failures++;
            $display("FAIL send_timeout value=%0h in_ready=%0b", v, in_ready_s);
        end else begin
            e.fs = fs; e.fw = fw; e.ovf = ovf; e.bad = bad;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("drain_empty", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_value = '0; in_sel = '0; in_base = '0;
        out_ready = 1'b1; clr_count = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
        check("rst_field", {24'd0, out_field_s}, 32'd0);
        check("rst_ovf", {31'd0, out_ovf_s}, 32'd0);
        check("rst_bad", {31'd0, out_bad_s}, 32'd0);
        check("rst_count", {24'd0, count_s}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Round trip and two-cycle latency
        send(16'hFF85, 2'd0, 8'h00, 8'h85, 8'h85, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", {31'd0, out_valid_s}, 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", {31'd0, out_valid_s}, 32'd1);
        @(posedge clk);
        #1;

        // Nibble packing
        send(16'h0007, 2'd2, 8'hA0, 8'hA7, 8'hA7, 1'b0, 1'b0);
        send(16'hFFF8, 2'd1, 8'h03, 8'h83, 8'h83, 1'b0, 1'b0);

        // Overflow: saturated vs wrapped
        send(16'd200,  2'd0, 8'h00, 8'h7F, 8'hC8, 1'b1, 1'b0);
        send(16'hFFF7, 2'd2, 8'h50, 8'h58, 8'h57, 1'b1, 1'b0);
        drain();
        check("count_after_ovf", {24'd0, count_s}, 32'd2);
        check("count_wrap_after_ovf", {24'd0, count_w}, 32'd2);

        // Boundaries
        send(16'hFF80, 2'd0, 8'h00, 8'h80, 8'h80, 1'b0, 1'b0);
        send(16'h007F, 2'd0, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b0);
        send(16'hFF7F, 2'd0, 8'h00, 8'h80, 8'h7F, 1'b1, 1'b0);
        send(16'h0080, 2'd0, 8'h00, 8'h7F, 8'h80, 1'b1, 1'b0);
        send(16'h0007, 2'd1, 8'h0F, 8'h7F, 8'h7F, 1'b0, 1'b0);
        send(16'hFFF8, 2'd2, 8'hC0, 8'hC8, 8'hC8, 1'b0, 1'b0);
        send(16'h0008, 2'd1, 8'h01, 8'h71, 8'h81, 1'b1, 1'b0);
        send(16'hFFFF, 2'd0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
        send(16'hFFFF, 2'd1, 8'h00, 8'hF0, 8'hF0, 1'b0, 1'b0);
        send(16'hFFFF, 2'd2, 8'h00, 8'h0F, 8'h0F, 1'b0, 1'b0);
        drain();
        check("count_after_bounds", {24'd0, count_s}, 32'd5);

        // Back-pressure: out_ready low for 5 cycles
        out_ready = 1'b0;
        fork
            begin
                send(16'h0011, 2'd0, 8'h00, 8'h11, 8'h11, 1'b0, 1'b0);
                send(16'h0022, 2'd0, 8'h00, 8'h22, 8'h22, 1'b0, 1'b0);
                send(16'h0033, 2'd0, 8'h00, 8'h33, 8'h33, 1'b0, 1'b0);
                send(16'h0044, 2'd0, 8'h00, 8'h44, 8'h44, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", {31'd0, in_ready_s}, 32'd0);
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("count_after_bp", {24'd0, count_s}, 32'd5);

        // Reserved select
        send(16'h1234, 2'd3, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b1);
        drain();
        check("count_after_rsvd", {24'd0, count_s}, 32'd6);

        // Clear coincident with an overflow transfer
        send(16'd200, 2'd0, 8'h00, 8'h7F, 8'hC8, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        drain();
        check("count_clr_wins", {24'd0, count_s}, 32'd0);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            send(16'hFF00, 2'd0, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0);
        drain();
        check("count_saturated", {24'd0, count_s}, 32'd255);

        // Reset with both stages full
        out_ready = 1'b0;
        send(16'h0001, 2'd0, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
        send(16'h0002, 2'd0, 8'h00, 8'h02, 8'h02, 1'b0, 1'b0);
        q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid_s}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready_s}, 32'd1);
        check("mid_rst_count", {24'd0, count_s}, 32'd0);
        check("mid_rst_field", {24'd0, out_field_s}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h0005, 2'd0, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_lat1", {31'd0, out_valid_s}, 32'd0);
        @(negedge clk);
        check("post_rst_lat2", {31'd0, out_valid_s}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
